// File: rtl/cci_mpf_shim_c0_req_buf_pkg.sv
// Types and helpers shared by the c0 read-request buffer shim: CCI header/channel
// structs, default sizing, and request/response decode functions.
package cci_mpf_shim_c0_req_buf_pkg;

   localparam int unsigned DEF_N_ENTRIES       = 32;
   localparam int unsigned DEF_ALMFULL_SLOTS   = 8;
   localparam int unsigned DEF_MAX_OUTSTANDING = 256;

   localparam int unsigned ADDR_W  = 42;
   localparam int unsigned MDATA_W = 16;
   localparam int unsigned DATA_W  = 64;

   typedef enum logic [3:0] {
      eREQ_RDLINE_I = 4'h0,
      eREQ_RDLINE_S = 4'h1,
      eREQ_WRLINE_I = 4'h2,
      eREQ_WRFENCE  = 4'h4
   } t_cci_req;

   typedef enum logic [3:0] {
      eRSP_RDLINE = 4'h0,
      eRSP_WRLINE = 4'h1,
      eRSP_UMSG   = 4'h4
   } t_cci_rsp;

   typedef struct packed {
      t_cci_req            req_type;
      logic [ADDR_W-1:0]   address;
      logic [MDATA_W-1:0]  mdata;
   } t_cci_mpf_c0_ReqMemHdr;

   typedef struct packed {
      logic                  valid;
      t_cci_mpf_c0_ReqMemHdr hdr;
   } t_if_cci_mpf_c0_Tx;

   typedef struct packed {
      logic                valid;
      t_cci_req            req_type;
      logic [ADDR_W-1:0]   address;
      logic [MDATA_W-1:0]  mdata;
      logic [DATA_W-1:0]   data;
   } t_if_cci_mpf_c1_Tx;

   typedef struct packed {
      logic                rspValid;
      t_cci_rsp            resp_type;
      logic [MDATA_W-1:0]  mdata;
      logic [DATA_W-1:0]   data;
   } t_if_cci_c0_Rx;

   typedef struct packed {
      logic                rspValid;
      t_cci_rsp            resp_type;
      logic [MDATA_W-1:0]  mdata;
   } t_if_cci_c1_Rx;

   // Width of a counter that must hold the value n itself.
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

   function automatic logic c0_tx_is_read_req(input t_if_cci_mpf_c0_Tx tx);
      return tx.valid && ((tx.hdr.req_type == eREQ_RDLINE_I) ||
                          (tx.hdr.req_type == eREQ_RDLINE_S));
   endfunction

   function automatic logic c0_rx_is_read_rsp(input t_if_cci_c0_Rx rx);
      return rx.rspValid && (rx.resp_type == eRSP_RDLINE);
   endfunction

endpackage

// File: rtl/cci_mpf_if.sv
// CCI-P style MPF connection bundle; to_fiu is the side driving requests toward
// the FIU, to_afu is the side facing the AFU.
interface cci_mpf_if;
   import cci_mpf_shim_c0_req_buf_pkg::*;

   t_if_cci_mpf_c0_Tx c0Tx;
   logic              c0TxAlmFull;
   t_if_cci_mpf_c1_Tx c1Tx;
   logic              c1TxAlmFull;
   t_if_cci_c0_Rx     c0Rx;
   t_if_cci_c1_Rx     c1Rx;
   logic              reset_n;

   modport to_fiu (output c0Tx, c1Tx, input c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx, reset_n);
   modport to_afu (input c0Tx, c1Tx, output c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx, reset_n);
endinterface

// File: rtl/cci_mpf_c0_req_fifo.sv
// Header FIFO for the c0 shim. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; otherwise it is dropped.
module cci_mpf_c0_req_fifo
   import cci_mpf_shim_c0_req_buf_pkg::*;
#(
   parameter int unsigned N_ENTRIES = DEF_N_ENTRIES
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enq_i,
   input  t_cci_mpf_c0_ReqMemHdr       enq_hdr_i,
   input  logic                        deq_i,
   output t_cci_mpf_c0_ReqMemHdr       head_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [$clog2(N_ENTRIES):0]  count_o,
   output logic [$clog2(N_ENTRIES):0]  count_d_o
);
   localparam int unsigned PTR_W = $clog2(N_ENTRIES);
   localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(N_ENTRIES);

   t_cci_mpf_c0_ReqMemHdr mem_q [N_ENTRIES];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_s, pop_s;

   assign full_o    = (count_q == CNT_MAX);
   assign empty_o   = (count_q == {(PTR_W+1){1'b0}});
   assign head_o    = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign count_d_o = count_d;

   always_comb begin
      pop_s    = deq_i & ~empty_o;
      push_s   = enq_i & (~full_o | pop_s);
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {(PTR_W+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= enq_hdr_i;
      end
   end

endmodule

// File: rtl/cci_mpf_shim_c0_req_buf.sv
// c0 read-request buffer shim: queues AFU read requests and releases them toward
// the FIU under FIU almost-full and read-credit control. Other channels pass through.
module cci_mpf_shim_c0_req_buf
   import cci_mpf_shim_c0_req_buf_pkg::*;
#(
   parameter int unsigned N_ENTRIES       = DEF_N_ENTRIES,
   parameter int unsigned ALMFULL_SLOTS   = DEF_ALMFULL_SLOTS,
   parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
)(
   input  logic                              clk,
   input  logic                              reset,
   cci_mpf_if.to_afu                         afu,
   cci_mpf_if.to_fiu                         fiu,
   output logic [$clog2(N_ENTRIES):0]        occupancy,
   output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
   output logic                              err_overflow,
   output logic                              err_underflow
);
   localparam int unsigned OCC_W = cnt_w(N_ENTRIES);
   localparam int unsigned OUT_W = cnt_w(MAX_OUTSTANDING);
   localparam logic [OCC_W-1:0] N_CNT   = OCC_W'(N_ENTRIES);
   localparam logic [OCC_W-1:0] ALM_CNT = OCC_W'(ALMFULL_SLOTS);
   localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);
   localparam logic [OUT_W-1:0] OUT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

   t_cci_mpf_c0_ReqMemHdr head_s;
   t_if_cci_mpf_c0_Tx     c0tx_q, c0tx_d;
   logic                  enq_s, rsp_s, issue_s, full_s, empty_s;
   logic [OCC_W-1:0]      occ_d_s;
   logic [OUT_W-1:0]      outst_q, outst_d;
   logic                  almfull_q, almfull_d, ovf_q, ovf_d, unf_q, unf_d;

   assign enq_s   = c0_tx_is_read_req(afu.c0Tx);
   assign rsp_s   = c0_rx_is_read_rsp(fiu.c0Rx);
   assign issue_s = ~empty_s & ~fiu.c0TxAlmFull & (outst_q < MAX_CNT);

   cci_mpf_c0_req_fifo #(.N_ENTRIES(N_ENTRIES)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .enq_i     (enq_s),
      .enq_hdr_i (afu.c0Tx.hdr),
      .deq_i     (issue_s),
      .head_o    (head_s),
      .full_o    (full_s),
      .empty_o   (empty_s),
      .count_o   (occupancy),
      .count_d_o (occ_d_s)
   );

   // Issue and response in the same cycle cancel, so they never underflow.
   always_comb begin
      c0tx_d.valid = issue_s;
      c0tx_d.hdr   = head_s;
      almfull_d    = ((N_CNT - occ_d_s) <= ALM_CNT);
      ovf_d        = ovf_q | (enq_s & full_s & ~issue_s);
      unf_d        = unf_q;
      outst_d      = outst_q;
      case ({issue_s, rsp_s})
         2'b10: outst_d = outst_q + OUT_ONE;
         2'b01: begin
            if (outst_q == {OUT_W{1'b0}}) begin
               unf_d = 1'b1;
            end else begin
               outst_d = outst_q - OUT_ONE;
            end
         end
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c0tx_q    <= '0;
         almfull_q <= 1'b1;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         outst_q   <= {OUT_W{1'b0}};
      end else begin
         c0tx_q    <= c0tx_d;
         almfull_q <= almfull_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         outst_q   <= outst_d;
      end
   end

   assign fiu.c0Tx         = c0tx_q;
   assign afu.c0TxAlmFull  = almfull_q;
   assign outstanding      = outst_q;
   assign err_overflow     = ovf_q;
   assign err_underflow    = unf_q;

   assign fiu.c1Tx         = afu.c1Tx;
   assign afu.c1TxAlmFull  = fiu.c1TxAlmFull;
   assign afu.c0Rx         = fiu.c0Rx;
   assign afu.c1Rx         = fiu.c1Rx;
   assign afu.reset_n      = fiu.reset_n;

endmodule
